// File: rtl/j_mmult_seq.sv
// Sequencer for a matrix multiply-accumulate: fetches mwidth operands from memory
// (row or column stride) and strobes the external MAC once per element.
module j_mmult_seq #(
    parameter int AW = 24
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    mwidth,
    input  logic          mcol,
    input  logic [AW-1:0] maddr,
    input  logic          mem_ack,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    reg_idx,
    output logic          acc_clr,
    output logic          mac_en,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {IDLE, LOAD, REQ, MAC, FIN} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt;
    logic [3:0]    mw_lat;
    logic          col_lat;
    logic [AW-1:0] stride;

    // Column stride is 2*width bytes; a latched width of 0 means 16 elements (32 bytes).
    always_comb begin
        stride = '0;
        if (col_lat)
            stride[5:0] = {(mw_lat == 4'd0), mw_lat, 1'b0};
        else
            stride[1] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = REQ;
            REQ:     if (mem_ack) state_nxt = MAC;
            MAC:     state_nxt = (cnt == 4'd1) ? FIN : REQ;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Strobes are registered from the next state so they line up exactly with the state register.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            mem_req  <= 1'b0;
            acc_clr  <= 1'b0;
            mac_en   <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            reg_idx  <= '0;
            mem_addr <= '0;
            cnt      <= '0;
            mw_lat   <= '0;
            col_lat  <= 1'b0;
        end else begin
            mem_req <= (state_nxt == REQ);
            acc_clr <= (state_nxt == LOAD);
            mac_en  <= (state_nxt == MAC);
            done    <= (state_nxt == FIN);
            busy    <= (state_nxt != IDLE);
            if (state == IDLE && start) begin
                cnt      <= mwidth;
                mw_lat   <= mwidth;
                col_lat  <= mcol;
                mem_addr <= maddr;
                reg_idx  <= '0;
            end else if (state == MAC && cnt != 4'd1) begin
                cnt      <= cnt - 4'd1;
                reg_idx  <= reg_idx + 4'd1;
                mem_addr <= mem_addr + stride;
            end
        end
    end

endmodule

// File: tb/tb_j_mmult_seq.sv
// Scoreboard bench for j_mmult_seq: a reference model queues the expected pulse
// sequence per job; a negedge monitor pops and compares every strobe the DUT emits.
module tb_j_mmult_seq;

    localparam int AW = 24;

    logic          sys_clk = 1'b0;
    logic          reset   = 1'b1;
    logic          start   = 1'b0;
    logic [3:0]    mwidth  = '0;
    logic          mcol    = 1'b0;
    logic [AW-1:0] maddr   = '0;
    logic          mem_ack = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [3:0]    reg_idx;
    logic          acc_clr;
    logic          mac_en;
    logic          busy;
    logic          done;

    j_mmult_seq #(.AW(AW)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .start   (start),
        .mwidth  (mwidth),
        .mcol    (mcol),
        .maddr   (maddr),
        .mem_ack (mem_ack),
        .mem_req (mem_req),
        .mem_addr(mem_addr),
        .reg_idx (reg_idx),
        .acc_clr (acc_clr),
        .mac_en  (mac_en),
        .busy    (busy),
        .done    (done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int            kind;   // 0 = acc_clr, 1 = mac_en, 2 = done
        logic [AW-1:0] addr;
        logic [3:0]    idx;
    } ev_t;

    ev_t queue_exp[$];
    int  tests = 0;
    int  fails = 0;
    int  ack_mode = 0;   // 0 = mem_ack tied high, 1 = delayed ack with stray acks outside REQ
    int  ack_delay = 0;
    int  done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: element k is fetched from base + k*stride (mod 2^AW) into register k.
    task automatic model_push(input logic [3:0] mw, input logic col, input logic [AW-1:0] base);
        int n;
        int strd;
        ev_t e;
        n = (mw == 0) ? 16 : int'(mw);
        strd = col ? 2 * n : 2;
        e.kind = 0; e.addr = '0; e.idx = '0;
        queue_exp.push_back(e);
        for (int k = 0; k < n; k++) begin
            e.kind = 1;
            e.addr = AW'((int'(base) + k * strd) % (1 << AW));
            e.idx  = 4'(k);
            queue_exp.push_back(e);
        end
        e.kind = 2; e.addr = '0; e.idx = '0;
        queue_exp.push_back(e);
    endtask

    // Monitor
    logic          prev_wait = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    initial begin
        ev_t e;
        forever begin
            @(negedge sys_clk);
            if (int'(acc_clr) + int'(mac_en) + int'(done) > 1)
                check("pulse_overlap", {29'd0, acc_clr, mac_en, done}, 32'd0);
            if (mem_req && prev_wait)
                check("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
            prev_wait = mem_req && !mem_ack;
            prev_addr = mem_addr;
            if (done) done_seen++;
            if (acc_clr || mac_en || done) begin
                if (queue_exp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: got clr/mac/done=%b%b%b expected none", acc_clr, mac_en, done);
                end else begin
                    e = queue_exp.pop_front();
                    check("pulse_kind", {29'd0, acc_clr, mac_en, done},
                          (e.kind == 0) ? 32'd4 : (e.kind == 1) ? 32'd2 : 32'd1);
                    if (mac_en && e.kind == 1) begin
                        check("mac_reg_idx", 32'(reg_idx), 32'(e.idx));
                        check("mac_mem_addr", 32'(mem_addr), 32'(e.addr));
                    end
                    if (done) check("busy_at_done", 32'(busy), 32'd1);
                end
            end
        end
    end

    // Memory responder
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (ack_mode == 0) begin
                mem_ack = 1'b1;
            end else if (mem_req) begin
                mem_ack = (wcnt >= ack_delay);
                wcnt++;
            end else begin
                wcnt = 0;
                mem_ack = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic run_job(input logic [3:0] mw, input logic col, input logic [AW-1:0] base,
                           input bit noise, input int exp_done);
        int cyc;
        model_push(mw, col, base);
        start = 1'b1; mwidth = mw; mcol = col; maddr = base;
        @(posedge sys_clk); #1;
        start = 1'b0;
        mwidth = 4'($urandom); mcol = 1'($urandom); maddr = AW'($urandom);
        cyc = 1;
        while (!done && cyc < 400) begin
            if (noise && busy && ($urandom_range(0, 2) == 0)) begin
                start = 1'b1; mwidth = 4'($urandom); maddr = AW'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge sys_clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (!done) begin
            tests++; fails++;
            $display("FAIL job_timeout: got no done expected done within 400 cycles");
        end else if (exp_done >= 0) begin
            check("done_cycle", 32'(cyc), 32'(exp_done));
        end
        @(posedge sys_clk); #1;
        check("idle_after_fin", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int guard;
        int done_before;
        logic [3:0] mw;
        // Reset with start and mem_ack asserted: reset must win.
        reset = 1'b1; start = 1'b1; mwidth = 4'd3;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_reg_idx", 32'(reg_idx), 32'd0);
        check("rst_pulses", {29'd0, acc_clr, mac_en, done}, 32'd0);
        start = 1'b0; reset = 1'b0;
        @(posedge sys_clk); #1;

        ack_mode = 0;
        run_job(4'd3, 1'b0, 24'h000100, 1'b0, 8);
        run_job(4'd4, 1'b1, 24'hFFFFF8, 1'b0, 10);
        run_job(4'd0, 1'b0, 24'h001000, 1'b0, 34);
        run_job(4'd1, 1'b0, 24'hFFFFFE, 1'b0, 4);

        ack_mode = 1; ack_delay = 3;
        run_job(4'd5, 1'b1, 24'h0000F0, 1'b1, -1);

        // Abort in the REQ state of the second element.
        model_push(4'd5, 1'b0, 24'h000200);
        start = 1'b1; mwidth = 4'd5; mcol = 1'b0; maddr = 24'h000200;
        @(posedge sys_clk); #1;
        start = 1'b0;
        guard = 0;
        while (!(mem_req && reg_idx == 4'd1) && guard < 100) begin
            @(posedge sys_clk); #1;
            guard++;
        end
        check("abort_reached_elem2", 32'(mem_req && reg_idx == 4'd1), 32'd1);
        queue_exp.delete();
        done_before = done_seen;
        reset = 1'b1; start = 1'b1;
        @(posedge sys_clk); #1;
        reset = 1'b0; start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_reg_idx", 32'(reg_idx), 32'd0);
        check("abort_pulses", {29'd0, acc_clr, mac_en, done}, 32'd0);
        repeat (20) @(posedge sys_clk);
        #1;
        check("abort_no_done", 32'(done_seen), 32'(done_before));
        check("abort_stays_idle", 32'(busy), 32'd0);
        run_job(4'd2, 1'b0, 24'h000300, 1'b0, -1);

        // Randomized jobs.
        for (int j = 0; j < 14; j++) begin
            mw = 4'($urandom);
            ack_mode = int'($urandom_range(0, 1));
            ack_delay = int'($urandom_range(0, 3));
            n = (mw == 0) ? 16 : int'(mw);
            run_job(mw, 1'($urandom), AW'($urandom), 1'($urandom),
                    (ack_mode == 0) ? 2 * n + 2 : -1);
        end

        repeat (3) @(posedge sys_clk);
        #1;
        check("scoreboard_empty", 32'(queue_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/j_mmult_seq.md
J_MMULT_SEQ -- requirements
Module: j_mmult_seq

Interface
REQ-001 SHALL expose parameter AW, default 24, meaning the matrix memory byte-address width.
REQ-002 SHALL have port sys_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle request to begin a matrix multiply-accumulate.
REQ-005 SHALL have port mwidth, input, 4 bits: element count, sampled on accepted start; 0 encodes 16.
REQ-006 SHALL have port mcol, input, 1 bit: sampled on accepted start; 0 = row mode, 1 = column mode.
REQ-007 SHALL have port maddr, input, AW bits: matrix base byte address, sampled on accepted start.
REQ-008 SHALL have port mem_ack, input, 1 bit: memory has returned the operand for the current mem_req.
REQ-009 SHALL have port mem_req, output, 1 bit: operand fetch request.
REQ-010 SHALL have port mem_addr, output, AW bits: fetch byte address.
REQ-011 SHALL have port reg_idx, output, 4 bits: left-operand register-bank half-word index.
REQ-012 SHALL have port acc_clr, output, 1 bit: clear the MAC accumulator.
REQ-013 SHALL have port mac_en, output, 1 bit: multiply-accumulate strobe.
REQ-014 SHALL have port busy, output, 1 bit: sequencer active.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, LOAD, REQ, MAC and FIN.
REQ-017 In IDLE, start=1 SHALL go to LOAD next cycle and latch mwidth into a 4-bit down counter cnt, plus mcol and maddr.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 LOAD (1 cycle) SHALL assert acc_clr=1, set reg_idx=0 and mem_addr=maddr, then go to REQ.
REQ-020 In REQ, mem_req SHALL be 1 with mem_addr stable; REQ SHALL be held until mem_ack=1, then go to MAC.
REQ-021 mem_ack SHALL be ignored outside REQ.
REQ-022 MAC (1 cycle) SHALL assert mac_en=1 with the current reg_idx.
REQ-023 In MAC with cnt==1, the next state SHALL be FIN.
REQ-024 In MAC with cnt!=1, the block SHALL: decrement cnt modulo 16, increment reg_idx modulo 16, advance mem_addr by the stride, and go to REQ.
REQ-025 Stride SHALL be 2 in row mode; in column mode it SHALL be 2*mwidth_latched, with 0 treated as 16 (stride 32).
REQ-026 mem_addr SHALL wrap modulo 2^AW.
REQ-027 Loaded cnt=0 SHALL yield exactly 16 MAC cycles (decrements 0->15->...->1).
REQ-028 FIN (1 cycle) SHALL assert done=1, then go to IDLE.
REQ-029 A new start SHALL be accepted no earlier than the cycle after FIN.
REQ-030 busy SHALL be 1 in LOAD, REQ, MAC and FIN, and 0 in IDLE.
REQ-031 acc_clr, mac_en and done SHALL be registered one-cycle pulses, never overlapping.
REQ-032 Minimum latency with mem_ack tied high: start at cycle 0, LOAD at 1, first REQ at 2, first MAC at 3, and each further element costs 2 cycles.
REQ-033 A mwidth=N job SHALL have its done pulse at cycle 2N+2.

Reset
REQ-034 reset=1 SHALL force IDLE at the next edge, with: mem_req=0, mac_en=0, acc_clr=0, done=0, busy=0, reg_idx=0, mem_addr=0, cnt=0.
REQ-035 Reset mid-operation SHALL abort without a done pulse, and the sequencer SHALL resume in IDLE the cycle after reset deasserts.
REQ-036 Reset SHALL take priority over start and mem_ack in the same cycle.

Verification
REQ-037 Row mode, mwidth=3, maddr=0x100, mem_ack tied 1 -> mem_addr 0x100/0x102/0x104; reg_idx 0/1/2; three mac_en pulses; done at cycle 8.
REQ-038 Column mode, mwidth=4, maddr=0xFFFFF8 -> mem_addr 0xFFFFF8, 0x000000, 0x000008, 0x000010 (wrap); four mac_en pulses.
REQ-039 mwidth=0, row mode -> 16 mac_en pulses; reg_idx 0..15; last mem_addr = maddr+0x1E; done at cycle 34.
REQ-040 mem_ack delayed 3 cycles per element, and start pulsed mid-job -> mem_req and mem_addr held stable while waiting; start ignored; element count unchanged.
REQ-041 reset asserted in the REQ state of element 2 -> all outputs 0 next cycle; no done pulse; a following start runs a clean job with acc_clr first.
